// File: rtl/bram_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_read_arbiter_if
//
// Bundles the request side (req/base/len), the return stream
// (grant/done/rd_*) and the BRAM read port of the shared weight/bias BRAM
// read scheduler into one interface.
//
// Modports:
//   slave  - the arbiter itself: takes requests and BRAM data, drives
//            grants, done pulses, the returned word stream and BRAM controls.
//   master - the surroundings: loaders driving requests plus the BRAM
//            returning read data.
// ---------------------------------------------------------------------------
interface bram_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_W      = 12
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base;
  logic [NUM_REQ*LEN_W-1:0]      req_len;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic                          rd_valid;
  logic [W-1:0]                  rd_data;
  logic [LEN_W-1:0]              rd_index;
  logic                          bram_en;
  logic                          bram_ren;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [W-1:0]                  bram_dout;

  modport slave (
    input  req, req_base, req_len, bram_dout,
    output grant, done, rd_valid, rd_data, rd_index, bram_en, bram_ren, bram_addr
  );

  modport master (
    output req, req_base, req_len, bram_dout,
    input  grant, done, rd_valid, rd_data, rd_index, bram_en, bram_ren, bram_addr
  );
endinterface

// File: rtl/bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// bram_read_arbiter
//
// Owns the single read port of the weight/bias BRAM and serves NUM_REQ
// loader requesters one burst at a time in round-robin order. A burst reads
// len consecutive words starting at base; the fixed BRAM read latency is
// realigned with a valid/index pipeline so that each returned word leaves
// with its offset inside the burst, and the owner gets a one-cycle done.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset, aborts any burst without done
//   bus  - bram_read_arbiter_if.slave: req/req_base/req_len in, grant/done,
//          rd_valid/rd_data/rd_index out, bram_en/bram_ren/bram_addr out,
//          bram_dout in
// ---------------------------------------------------------------------------
module bram_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_W      = 12,
  parameter int RD_LAT     = 2
) (
  input  logic                clk,
  input  logic                rst,
  bram_read_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [NUM_REQ-1:0]             grant_q, grant_d;
  logic [PTR_W-1:0]               rr_q, rr_d;
  logic [PTR_W-1:0]               owner_q, owner_d;
  logic                           en_q, en_d;
  logic                           ren_q, ren_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [LEN_W-1:0]               cnt_q, cnt_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [RD_LAT-1:0]              pv_q, pv_d;
  logic [RD_LAT-1:0][LEN_W-1:0]   pi_q, pi_d;

  logic [ADDR_WIDTH-1:0]          base_arr [NUM_REQ];
  logic [LEN_W-1:0]               len_arr  [NUM_REQ];

  int                             cand;
  logic [PTR_W-1:0]               cand_idx;
  logic                           pick_found;
  logic [PTR_W-1:0]               pick_idx;

  // Split the flat per-requester base/len buses into arrays so the winner's
  // fields can be selected with a plain index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign base_arr[g] = bus.req_base[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[g]  = bus.req_len[g*LEN_W +: LEN_W];
  end

  // Round-robin pick: first asserted request scanning upward from rr_q with
  // wrap-around. Only consulted while IDLE.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!pick_found && bus.req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state logic. The valid/index pipeline stands in for the BRAM read
  // latency: an entry is pushed for every address issued and emerges from
  // the last stage exactly when that address's data appears on bram_dout.
  // DRAIN leaves once the pipeline would be empty after this edge, which
  // places DONE one cycle after the last returned word.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    en_d    = en_q;
    ren_d   = ren_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;

    pv_d[0] = (state_q == ISSUE);
    pi_d[0] = (state_q == ISSUE) ? cnt_q : '0;
    for (int s = 1; s < RD_LAT; s++) begin
      pv_d[s] = pv_q[s-1];
      pi_d[s] = pi_q[s-1];
    end

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          en_d    = 1'b1;
          cnt_d   = '0;
          len_d   = len_arr[pick_idx];
          if (len_arr[pick_idx] == '0) begin
            state_d = DONE;
          end else begin
            ren_d   = 1'b1;
            addr_d  = base_arr[pick_idx];
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == len_q - LEN_W'(1)) begin
          ren_d   = 1'b0;
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q + LEN_W'(1);
        end
      end
      DRAIN: begin
        if (pv_d == '0) state_d = DONE;
      end
      DONE: begin
        grant_d = '0;
        en_d    = 1'b0;
        rr_d    = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any in-flight burst and its pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      owner_q <= '0;
      en_q    <= 1'b0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      pv_q    <= '0;
      pi_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      en_q    <= en_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pv_q    <= pv_d;
      pi_q    <= pi_d;
    end
  end

  // done is the owner's grant bit during the single DONE cycle.
  assign bus.done      = (state_q == DONE) ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.bram_en   = en_q;
  assign bus.bram_ren  = ren_q;
  assign bus.bram_addr = addr_q;
  assign bus.rd_valid  = pv_q[RD_LAT-1];
  assign bus.rd_index  = pi_q[RD_LAT-1];
  assign bus.rd_data   = bus.bram_dout;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_read_arbiter
//
// Bench for bram_read_arbiter: a BRAM model with RD_LAT latency, a table of
// single-burst vectors, hand-written round-robin and reset sequences, and a
// randomized phase checked against a burst-timeline reference model.
// ---------------------------------------------------------------------------
module tb_bram_read_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int W          = 8;
  localparam int ADDR_WIDTH = 15;
  localparam int LEN_W      = 12;
  localparam int RD_LAT     = 2;
  localparam int ASPACE     = 1 << ADDR_WIDTH;

  typedef logic [$clog2(NUM_REQ)-1:0] idx_t;

  typedef struct {
    int                 who;
    int                 base;
    int                 len;
    int                 dropAt;
    logic [NUM_REQ-1:0] expGrant;
    int                 expDone;
    int                 expValid;
    int                 expRen;
    int                 expLastAddr;
    int                 expFirstValid;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_REQ-1:0]    reqV;
  logic [ADDR_WIDTH-1:0] baseA [NUM_REQ];
  logic [LEN_W-1:0]      lenA  [NUM_REQ];
  logic [W-1:0]          bramPipe [RD_LAT];

  int checks = 0;
  int passes = 0;

  int mActive, mOwner, mStart, mLen, mBase, mDoneR, mNextFree, mRr;
  int st [NUM_REQ];

  always #5 clk = ~clk;

  bram_read_arbiter_if #(.NUM_REQ(NUM_REQ), .W(W), .ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_W)) bus ();

  bram_read_arbiter #(
    .NUM_REQ(NUM_REQ), .W(W), .ADDR_WIDTH(ADDR_WIDTH), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Requester-side drive of the flat request buses.
  assign bus.req = reqV;
  for (genvar g = 0; g < NUM_REQ; g++) begin : gPack
    assign bus.req_base[g*ADDR_WIDTH +: ADDR_WIDTH] = baseA[g];
    assign bus.req_len[g*LEN_W +: LEN_W]            = lenA[g];
  end

  function automatic logic [W-1:0] memFn(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] t;
    t = a * 15'd37 + 15'd11;
    return t[7:0] ^ t[14:7];
  endfunction

  // BRAM model: data for an address read appears RD_LAT cycles later.
  always @(posedge clk) begin
    bramPipe[0] <= bus.bram_ren ? memFn(bus.bram_addr) : '0;
    for (int s = 1; s < RD_LAT; s++) bramPipe[s] <= bramPipe[s-1];
  end
  assign bus.bram_dout = bramPipe[RD_LAT-1];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_grant"}, 32'(bus.grant), 0);
    checkOutput({tag, "_done"}, 32'(bus.done), 0);
    checkOutput({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
    checkOutput({tag, "_bram_en"}, 32'(bus.bram_en), 0);
    checkOutput({tag, "_bram_ren"}, 32'(bus.bram_ren), 0);
    checkOutput({tag, "_bram_addr"}, 32'(bus.bram_addr), 0);
    checkOutput({tag, "_rd_index"}, 32'(bus.rd_index), 0);
  endtask

  task automatic applyStimulus(input int who, input int base, input int len);
    baseA[idx_t'(who)] = ADDR_WIDTH'(base);
    lenA[idx_t'(who)]  = LEN_W'(len);
    reqV[idx_t'(who)]  = 1'b1;
  endtask

  // Called right after a grant edge; watches the burst cycle by cycle.
  task automatic observeBurst(input int who, input int base, input int dropAt,
                              output logic [NUM_REQ-1:0] g0, output int doneCyc,
                              output int nValid, output int nRen, output int lastAddr,
                              output int firstValid, output int seqErr);
    doneCyc = -1; nValid = 0; nRen = 0; lastAddr = -1; firstValid = -1; seqErr = 0; g0 = '0;
    for (int c = 0; c < 40 && doneCyc < 0; c++) begin
      @(negedge clk);
      if (c == 0) g0 = bus.grant;
      if (bus.bram_ren) begin
        nRen++;
        lastAddr = int'(bus.bram_addr);
      end
      if (bus.rd_valid) begin
        if (firstValid < 0) firstValid = c;
        if (int'(bus.rd_index) != nValid) seqErr++;
        if (bus.rd_data !== memFn(ADDR_WIDTH'(base + nValid))) seqErr++;
        nValid++;
      end
      if (bus.done != '0) begin
        doneCyc = c;
        if (bus.done != (NUM_REQ'(1) << who)) seqErr++;
      end
      if (c == dropAt) reqV[idx_t'(who)] = 1'b0;
    end
    reqV[idx_t'(who)] = 1'b0;
  endtask

  // Reference model: at an edge where the arbiter is free, the requester
  // chosen by round-robin from the bench's own request levels starts a
  // burst whose whole timeline follows from base, len and RD_LAT.
  task automatic modelEdge(input int e);
    int found;
    if (e >= mNextFree) begin
      found = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int c2 = (mRr + k) % NUM_REQ;
        if (found < 0 && reqV[idx_t'(c2)]) found = c2;
      end
      if (found >= 0) begin
        mActive   = 1;
        mOwner    = found;
        mStart    = e;
        mLen      = int'(lenA[idx_t'(found)]);
        mBase     = int'(baseA[idx_t'(found)]);
        mDoneR    = (mLen == 0) ? 0 : mLen + RD_LAT;
        mNextFree = e + mDoneR + 2;
        mRr       = (found + 1) % NUM_REQ;
        st[idx_t'(found)] = 2;
      end else begin
        mNextFree = e + 1;
      end
    end
  endtask

  task automatic checkCycle(input int e);
    int r;
    logic [NUM_REQ-1:0] expG, expD;
    logic expRen, expV;
    r = e - mStart;
    expG = '0; expD = '0; expRen = 1'b0; expV = 1'b0;
    if (mActive != 0 && r >= 0 && r <= mDoneR) expG = NUM_REQ'(1) << mOwner;
    if (mActive != 0 && r == mDoneR) expD = NUM_REQ'(1) << mOwner;
    if (mActive != 0 && r >= 0 && r < mLen) expRen = 1'b1;
    if (mActive != 0 && r >= RD_LAT && r < mLen + RD_LAT) expV = 1'b1;
    checkOutput("rand_grant", 32'(bus.grant), 32'(expG));
    checkOutput("rand_done", 32'(bus.done), 32'(expD));
    checkOutput("rand_bram_ren", 32'(bus.bram_ren), 32'(expRen));
    checkOutput("rand_bram_en", 32'(bus.bram_en), 32'(expG != '0));
    checkOutput("rand_rd_valid", 32'(bus.rd_valid), 32'(expV));
    if (expRen) checkOutput("rand_bram_addr", 32'(bus.bram_addr), (mBase + r) % ASPACE);
    if (expV) begin
      checkOutput("rand_rd_index", 32'(bus.rd_index), r - RD_LAT);
      checkOutput("rand_rd_data", 32'(bus.rd_data),
                  32'(memFn(ADDR_WIDTH'((mBase + r - RD_LAT) % ASPACE))));
    end
  endtask

  function automatic logic [ADDR_WIDTH-1:0] randBase();
    if ($urandom_range(0, 3) == 0) return ADDR_WIDTH'(32760 + $urandom_range(0, 7));
    return ADDR_WIDTH'($urandom_range(0, ASPACE - 1));
  endfunction

  task automatic driveRandom(input int e);
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_t ii = idx_t'(i);
      if (st[ii] == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          baseA[ii] = randBase();
          lenA[ii]  = LEN_W'($urandom_range(0, 6));
          reqV[ii]  = 1'b1;
          st[ii]    = 1;
        end
      end else if (st[ii] == 2) begin
        if (mActive != 0 && mOwner == i && e == mStart + mDoneR) begin
          if ($urandom_range(0, 1) == 1) begin
            baseA[ii] = randBase();
            lenA[ii]  = LEN_W'($urandom_range(0, 6));
            reqV[ii]  = 1'b1;
            st[ii]    = 1;
          end else begin
            reqV[ii] = 1'b0;
            st[ii]   = 0;
          end
        end else begin
          if ($urandom_range(0, 3) == 0) begin
            baseA[ii] = randBase();
            lenA[ii]  = LEN_W'($urandom_range(0, 6));
          end
          if ($urandom_range(0, 7) == 0) reqV[ii] = 1'b0;
        end
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    reqV = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Main sequence: reset, vector table, round-robin, mid-burst reset,
  // then the randomized phase.
  initial begin
    vec_t vecs [6];
    logic [NUM_REQ-1:0] g0;
    int doneCyc, nValid, nRen, lastAddr, firstValid, seqErr;
    int owners [5];
    int grantCyc [5];
    int nG, ow, overlapErr, doneSeen, grantSeen;
    logic [NUM_REQ-1:0] prevG;

    vecs[0] = '{0, 16440, 8, -1, 4'b0001, 10, 8, 8, 16447, 2};
    vecs[1] = '{1, 32766, 4, -1, 4'b0010,  6, 4, 4,     1, 2};
    vecs[2] = '{2,   100, 0, -1, 4'b0100,  0, 0, 0,    -1, -1};
    vecs[3] = '{3,     5, 1, -1, 4'b1000,  3, 1, 1,     5, 2};
    vecs[4] = '{0,  4095, 5,  1, 4'b0001,  7, 5, 5,  4099, 2};
    vecs[5] = '{1, 32767, 2,  0, 4'b0010,  4, 2, 2,     0, 2};

    rst = 1'b1;
    reqV = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      baseA[idx_t'(i)] = '0;
      lenA[idx_t'(i)]  = '0;
    end
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      applyStimulus(vecs[v].who, vecs[v].base, vecs[v].len);
      @(posedge clk);
      observeBurst(vecs[v].who, vecs[v].base, vecs[v].dropAt,
                   g0, doneCyc, nValid, nRen, lastAddr, firstValid, seqErr);
      checkOutput($sformatf("vec%0d_grant", v), 32'(g0), 32'(vecs[v].expGrant));
      checkOutput($sformatf("vec%0d_done_cycle", v), doneCyc, vecs[v].expDone);
      checkOutput($sformatf("vec%0d_valid_count", v), nValid, vecs[v].expValid);
      checkOutput($sformatf("vec%0d_ren_count", v), nRen, vecs[v].expRen);
      checkOutput($sformatf("vec%0d_last_addr", v), lastAddr, vecs[v].expLastAddr);
      checkOutput($sformatf("vec%0d_first_valid", v), firstValid, vecs[v].expFirstValid);
      checkOutput($sformatf("vec%0d_seq_errors", v), seqErr, 0);
      repeat (3) @(negedge clk);
    end

    // Round-robin with every requester held high, len 2 each.
    doReset();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1000 * (i + 1), 2);
    nG = 0; overlapErr = 0; prevG = '0;
    for (int c = 0; c < 80 && nG < 5; c++) begin
      @(negedge clk);
      if (bus.grant != '0 && prevG == '0) begin
        ow = -1;
        for (int b = 0; b < NUM_REQ; b++) if (bus.grant[idx_t'(b)]) ow = b;
        owners[nG]   = ow;
        grantCyc[nG] = c;
        nG++;
      end
      if ($countones(bus.grant) > 1) overlapErr++;
      if (bus.rd_valid && bus.grant == '0) overlapErr++;
      prevG = bus.grant;
    end
    reqV = '0;
    checkOutput("rr_grant_count", nG, 5);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("rr_owner%0d", k), owners[k], k % NUM_REQ);
      checkOutput($sformatf("rr_grant_cycle%0d", k), grantCyc[k], 6 * k);
    end
    checkOutput("rr_overlap_errors", overlapErr, 0);
    repeat (12) @(negedge clk);

    // Move the pointer to 3, then reset in the middle of a len-8 burst.
    @(negedge clk);
    applyStimulus(2, 300, 1);
    @(posedge clk);
    observeBurst(2, 300, -1, g0, doneCyc, nValid, nRen, lastAddr, firstValid, seqErr);
    checkOutput("pre_reset_done_cycle", doneCyc, 3);
    repeat (3) @(negedge clk);
    applyStimulus(0, 200, 8);
    @(posedge clk);
    repeat (RD_LAT + 4) @(negedge clk);
    checkOutput("midburst_rd_valid", 32'(bus.rd_valid), 1);
    checkOutput("midburst_rd_index", 32'(bus.rd_index), 3);
    #2 rst = 1'b1;
    #1 checkIdleOutputs("async_reset");
    reqV = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    doneSeen = 0; grantSeen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done != '0) doneSeen++;
      if (bus.grant != '0) grantSeen++;
    end
    checkOutput("aborted_no_done", doneSeen, 0);
    checkOutput("aborted_no_grant", grantSeen, 0);
    applyStimulus(1, 77, 1);
    applyStimulus(3, 88, 1);
    @(posedge clk);
    observeBurst(1, 77, -1, g0, doneCyc, nValid, nRen, lastAddr, firstValid, seqErr);
    checkOutput("post_reset_grant1", 32'(g0), 32'(4'b0010));
    checkOutput("post_reset_done1", doneCyc, 3);
    checkOutput("post_reset_addr1", lastAddr, 77);
    checkOutput("post_reset_seq1", seqErr, 0);
    @(posedge clk);
    @(posedge clk);
    observeBurst(3, 88, -1, g0, doneCyc, nValid, nRen, lastAddr, firstValid, seqErr);
    checkOutput("post_reset_grant3", 32'(g0), 32'(4'b1000));
    checkOutput("post_reset_done3", doneCyc, 3);
    checkOutput("post_reset_valid3", nValid, 1);

    // Randomized phase against the timeline model.
    doReset();
    for (int i = 0; i < NUM_REQ; i++) st[idx_t'(i)] = 0;
    mActive = 0; mOwner = 0; mStart = -1000; mLen = 0; mBase = 0;
    mDoneR = 0; mNextFree = 0; mRr = 0;
    for (int e = 0; e < 3000; e++) begin
      @(posedge clk);
      modelEdge(e);
      @(negedge clk);
      checkCycle(e);
      driveRandom(e);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bram_read_arbiter.md
# bram_read_arbiter

Shared-BRAM read scheduler for the parameter-loading path. It owns the single read port of the weight/bias BRAM and serves up to NUM_REQ loader requesters. Each requester asks for a burst of consecutive words (base address, length). The arbiter grants requesters one at a time in round-robin order, issues the burst addresses, realigns the fixed BRAM read latency, and streams indexed words back with a per-requester done pulse. It sits between the per-layer weight/bias loaders and the BRAM instance in the top level.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- W, 8, BRAM word width
- ADDR_WIDTH, 15, BRAM address width
- LEN_W, 12, burst length counter width
- RD_LAT, 2, BRAM read latency in cycles (1..4)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request level; held until matching done
- req_base  input  NUM_REQ*ADDR_WIDTH  base address, slice i for requester i
- req_len  input  NUM_REQ*LEN_W  word count, slice i for requester i
- grant  output  NUM_REQ  one-hot owner of the current burst, 0 when idle
- done  output  NUM_REQ  one-cycle pulse on the owner's bit at burst completion
- rd_valid  output  1  rd_data/rd_index valid this cycle
- rd_data  output  W  returned word (bram_dout passed through)
- rd_index  output  LEN_W  word offset within burst (0..len-1)
- bram_en  output  1  BRAM enable
- bram_ren  output  1  BRAM read enable
- bram_addr  output  ADDR_WIDTH  BRAM address
- bram_dout  input  W  BRAM read data, valid RD_LAT cycles after address

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - rr_ptr points to the highest-priority requester.
  - Pick the first asserted req[i] scanning from rr_ptr upward, with wrap.
  - On that edge: latch base and len, grant <= onehot(i), bram_en <= 1, cnt <= 0.
  - len==0: go directly to DONE. No read is issued and bram_ren stays 0.
  - Otherwise: bram_ren <= 1, bram_addr <= base, go to ISSUE.
- ISSUE, each edge:
  - Push {valid=1, index=cnt} into an RD_LAT-deep pipeline.
  - If cnt==len-1: bram_ren <= 0, go to DRAIN.
  - Else: bram_addr <= bram_addr+1 (wraps mod 2^ADDR_WIDTH), cnt <= cnt+1.
- DRAIN: shift the pipeline with zeros. When the pipeline is empty, go to DONE.
- DONE (exactly one cycle):
  - done[i] = 1.
  - Exit edge: grant <= 0, bram_en <= 0, rr_ptr <= (i+1) mod NUM_REQ, go to IDLE.
- rd_valid and rd_index come from the pipeline output stage. rd_data = bram_dout, combinational.
- Request handling:
  - req, base and len are sampled only in IDLE.
  - Changes while granted are ignored; dropping req mid-burst does not abort it.
  - A requester that keeps req high after done competes again only after all other pending requesters have been served.
- Reset (any time, including mid-burst):
  - grant, done, rd_valid, bram_en, bram_ren = 0.
  - bram_addr, rd_index, cnt, rr_ptr = 0; pipeline cleared; state = IDLE.
  - In-flight reads are discarded; no done is produced for an aborted burst.

## Timing
- Grant latency: 1 cycle from req sampled in IDLE to grant and first address.
- Words are presented on consecutive cycles, with no bubbles.
- Word k is presented at burst cycle k, counting the grant edge as cycle 0. rd_valid for word k is high in cycle k+RD_LAT.
- done pulses in cycle len+RD_LAT, the cycle after the last rd_valid.
- grant falls on the following edge.
- Next grant no earlier than 2 cycles after done: DONE→IDLE edge, then the IDLE→ISSUE edge.
- Total occupancy per burst of len≥1: len+RD_LAT+2 cycles, from the grant edge to the next possible grant.
- len==0: grant high 1 cycle, done in that same cycle, no rd_valid.

## Test plan
- Single burst: req[0] with base 16440, len 8, RD_LAT 2.
  - bram_addr runs 16440..16447 on 8 consecutive cycles.
  - rd_valid high 8 cycles with rd_index 0..7.
  - done[0] pulses 1 cycle after the last rd_valid; grant returns to 0.
- Round-robin: req[3:0]=1111 held, each len 2.
  - Grants in order 0,1,2,3,0.
  - Never two bits high; no rd_valid overlaps between bursts.
- Address wrap: base 32766, len 4, ADDR_WIDTH 15.
  - Addresses 32766, 32767, 0, 1; rd_index 0..3.
- Zero length: req[2] with len 0.
  - grant[2] and done[2] high together for 1 cycle.
  - bram_ren never asserted, rd_valid never asserted.
- Reset mid-burst: assert rst asynchronously at word 3 of a len-8 burst.
  - All outputs 0 immediately and no done.
  - After release, a new req[1] with len 1 is granted normally; rr_ptr restarts at 0.
- Request drop: deassert req[0] mid-burst.
  - Burst still completes all len words and pulses done[0].
